shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequential barrel-shift controller.
// The block applies one 1-bit shift step per clock: LSL, LSR, SRA or ROR.
// A three-state FSM (IDLE / SHIFT / DONE) drives it, and a down-counter
// holds the number of steps still to do.
// Optional feature macro: SHIFT_CLAMP_EN.
//   Defined  : the amount is clamped to W (LSL/LSR/SRA) or reduced mod W (ROR),
//              so the worst-case latency is W cycles.
//   Undefined: the amount is used as given, so the worst case is 2^W-1 cycles.
// The result is the same in both builds.
module shift_seq_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] data,
  input  logic [W-1:0] shift_amt,
  input  logic [1:0]   shift_type,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  typedef logic [W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_t;

  state_t state;
  state_t state_nxt;
  word_t  work;
  word_t  count;
  shift_t op;
  word_t  eff_amt;

  // One 1-bit step of the latched shift kind.
  function automatic word_t step(input word_t r, input shift_t t);
    case (t)
      OP_LSL:  step = {r[W-2:0], 1'b0};
      OP_LSR:  step = {1'b0, r[W-1:1]};
      OP_SRA:  step = {r[W-1], r[W-1:1]};
      default: step = {r[0], r[W-1:1]};
    endcase
  endfunction

`ifdef SHIFT_CLAMP_EN
  localparam word_t W_VAL = word_t'(W);

  // Effective step count: a shift of W or more steps leaves the same LSL/LSR/SRA
  // result as W steps, and a rotation by W steps returns the operand unchanged.
  always_comb begin
    // NOTE: give every combinational output a default first, so every path
    // assigns it and no latch is inferred.
    eff_amt = shift_amt;
    if (shift_type == OP_ROR)
      eff_amt = shift_amt % W_VAL;
    else if (shift_amt > W_VAL)
      eff_amt = W_VAL;
  end
`else
  // Effective step count: the requested amount, used without any change.
  always_comb begin
    eff_amt = shift_amt;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers
    // update together at the clock edge.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (eff_amt == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        // The last step happens on the edge where count goes from 1 to 0.
        if (count <= word_t'(1)) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath. Operands are captured only on an accepted start, so later input
  // changes do not affect an operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register gets a reset value, so result reads 0 as
    // soon as reset is asserted.
    if (!rst_n) begin
      work  <= '0;
      count <= '0;
      op    <= OP_LSL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work  <= data;
            count <= eff_amt;
            op    <= shift_t'(shift_type);
          end
        end
        ST_SHIFT: begin
          work  <= step(work, op);
          count <= count - word_t'(1);
        end
        default: ;
      endcase
    end
  end

  // Output decode. busy and done come from distinct states, so they are never
  // high together.
  always_comb begin
    busy   = (state == ST_SHIFT);
    done   = (state == ST_DONE);
    result = work;
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl (W = 8).
// Directed vectors with hand-computed answers feed a scoreboard queue.
// A monitor on the falling edge pops an entry on every done pulse.
// For each done it checks result, the busy-cycle count, the done timing,
// and that result holds in the next cycle.
// Build with or without SHIFT_CLAMP_EN; only the expected latencies differ.
module tb_shift_seq_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data;
  logic [W-1:0] shift_amt;
  logic [1:0]   shift_type;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  shift_seq_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data       (data),
    .shift_amt  (shift_amt),
    .shift_type (shift_type),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] res;
    int           n;
    int           acc;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: the checking side of the scoreboard.
  int           busy_cnt = 0;
  bit           hold_pend = 0;
  logic [W-1:0] hold_val;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt  = 0;
      hold_pend = 0;
    end else begin
      if (busy || done) check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (hold_pend) begin
        check("result_hold", {24'd0, result}, {24'd0, hold_val});
        hold_pend = 0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", {24'd0, result}, {24'd0, e.res});
          check("busy_cycles", busy_cnt, e.n);
          check("done_timing", cyc, e.acc + e.n);
          hold_val  = e.res;
          hold_pend = 1;
        end
        busy_cnt = 0;
      end
    end
  end

  function automatic int pick_n(input int n_clamp, input int n_raw);
`ifdef SHIFT_CLAMP_EN
    pick_n = n_clamp;
`else
    pick_n = n_raw;
`endif
  endfunction

  // Wait in IDLE and issue one start. The inputs are scrambled right after the
  // accepting edge.
  task automatic run_op(input logic [1:0] t, input logic [W-1:0] d, input logic [W-1:0] a,
                        input logic [W-1:0] res, input int n, input bit push);
    int guard = 0;
    exp_t e;
    while ((busy || done) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) begin
      errors++;
      checks++;
      $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", busy, done, guard);
    end
    data       = d;
    shift_amt  = a;
    shift_type = t;
    start      = 1'b1;
    e.res = res;
    e.n   = n;
    e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    data       = 8'($urandom);
    shift_amt  = 8'($urandom);
    shift_type = 2'($urandom);
  endtask

  initial begin
    int guard;
    int a0;
    rst_n      = 1'b0;
    start      = 1'b0;
    data       = '0;
    shift_amt  = '0;
    shift_type = 2'b00;
    #1;
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // type, data, amount, result, busy cycles
    run_op(2'b00, 8'h81, 8'd3,   8'h08, 3, 1);
    run_op(2'b10, 8'h90, 8'd2,   8'hE4, 2, 1);
    run_op(2'b01, 8'h90, 8'd2,   8'h24, 2, 1);
    run_op(2'b11, 8'h01, 8'd1,   8'h80, 1, 1);
    run_op(2'b11, 8'h01, 8'd9,   8'h80, pick_n(1, 9), 1);
    run_op(2'b00, 8'h5A, 8'd0,   8'h5A, 0, 1);
    run_op(2'b11, 8'h5A, 8'd0,   8'h5A, 0, 1);
    run_op(2'b10, 8'h5A, 8'd0,   8'h5A, 0, 1);
    run_op(2'b00, 8'hA5, 8'd200, 8'h00, pick_n(8, 200), 1);
    run_op(2'b10, 8'h80, 8'd10,  8'hFF, pick_n(8, 10), 1);
    run_op(2'b01, 8'hFF, 8'd7,   8'h01, 7, 1);
    run_op(2'b11, 8'h96, 8'd4,   8'h69, 4, 1);
    run_op(2'b11, 8'h96, 8'd8,   8'h96, pick_n(0, 8), 1);
    run_op(2'b10, 8'h7F, 8'd3,   8'h0F, 3, 1);

    // Hold start high: a new operation may begin only from IDLE, and each
    // operation gives one done. With N=1 each op takes 3 cycles (SHIFT, DONE, IDLE).
    guard = 0;
    while ((busy || done) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    data       = 8'h81;
    shift_amt  = 8'd1;
    shift_type = 2'b00;
    start      = 1'b1;
    a0 = cyc + 1;
    for (int k = 0; k < 3; k++) sb.push_back('{res: 8'h02, n: 1, acc: a0 + 3 * k});
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != a0 + 6 && guard < 100);
    start = 1'b0;

    // Assert reset in the middle of a shift: the outputs go to 0 at once and no
    // done is produced (the monitor would flag one as spurious).
    run_op(2'b00, 8'h11, 8'd20, 8'h00, 0, 0);
    repeat (2) @(negedge clk);
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy",   {31'd0, busy}, 32'd0);
    check("midreset_done",   {31'd0, done}, 32'd0);
    check("midreset_result", {24'd0, result}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (25) @(negedge clk);

    // Check that the block still works after the reset.
    run_op(2'b01, 8'hC3, 8'd2, 8'h30, 2, 1);

    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
